// File: rtl/qar_icache_if.sv
// qar_icache_if: fetch-side and imem-side handshake bundle.
// slave = the cache, master = core fetch plus instruction memory.
interface qar_icache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic [31:0]           fetch_rdata;
  logic                  imem_valid;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic [31:0]           imem_rdata;

  modport slave (
    input  fetch_valid, fetch_addr,
    input  imem_ready, imem_rdata,
    output fetch_ready, fetch_rdata,
    output imem_valid, imem_addr
  );

  modport master (
    output fetch_valid, fetch_addr,
    output imem_ready, imem_rdata,
    input  fetch_ready, fetch_rdata,
    input  imem_valid, imem_addr
  );
endinterface

// File: rtl/qar_icache.sv
// qar_icache: direct-mapped, one-word-per-line read-only I-cache.
// Hit/miss counters built only with QAR_ICACHE_STATS_EN defined.
module qar_icache #(
  parameter int ENTRIES    = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  qar_icache_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ENTRIES-1:0]    r_valid;
  logic [TAG_W-1:0]      r_tags  [ENTRIES];
  logic [31:0]           r_words [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_buf;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_drop;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_ridx;
  logic [TAG_W-1:0] w_rtag;
  logic             w_req;
  logic             w_hit;
  logic             w_hit_go;
  logic             w_miss;
  logic             w_fill;
  logic             w_skip;
  logic             w_unused;

  assign w_idx  = bus.fetch_addr[IDX_W+1:2];
  assign w_tag  = bus.fetch_addr[ADDR_WIDTH-1:IDX_W+2];
  assign w_ridx = r_addr[IDX_W+1:2];
  assign w_rtag = r_addr[ADDR_WIDTH-1:IDX_W+2];

  // The request is still high in its ready cycle; don't re-accept it.
  assign w_req  = bus.fetch_valid && !r_ready;
  assign w_hit  = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
  assign w_skip = r_drop || !bus.fetch_valid;

  assign w_unused = &{1'b0, bus.fetch_addr[1:0]};

  assign bus.imem_valid  = (r_state == S_REFILL);
  assign bus.imem_addr   = r_addr;
  assign bus.fetch_ready = r_ready;
  assign bus.fetch_rdata = r_rdata;

  // Next-state and per-cycle event decode
  always_comb begin
    w_next   = r_state;
    w_hit_go = 1'b0;
    w_miss   = 1'b0;
    w_fill   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_hit_go = 1'b1;
            w_next   = S_RESP;
          end else begin
            w_miss = 1'b1;
            w_next = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (bus.imem_ready) begin
          w_fill = 1'b1;
          w_next = w_skip ? S_IDLE : S_RESP;
        end
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, response path, refill address and valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_addr  <= '0;
      r_buf   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (r_state == S_RESP);
      if (r_state == S_RESP)
        r_rdata <= r_buf;
      if (w_miss) begin
        r_addr <= {bus.fetch_addr[ADDR_WIDTH-1:2], 2'b00};
        r_drop <= 1'b0;
      end else if (r_state == S_REFILL && !bus.fetch_valid) begin
        r_drop <= 1'b1;
      end
      if (w_hit_go)
        r_buf <= r_words[w_idx];
      else if (w_fill)
        r_buf <= bus.imem_rdata;
      if (flush)
        r_valid <= '0;
      else if (w_fill)
        r_valid[w_ridx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tags[w_ridx]  <= w_rtag;
      r_words[w_ridx] <= bus.imem_rdata;
    end
  end

`ifdef QAR_ICACHE_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  // Free-running hit/miss statistics, untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_hit_go)
        r_hits <= r_hits + 32'd1;
      if (w_miss)
        r_misses <= r_misses + 32'd1;
    end
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_qar_icache.sv
// tb_qar_icache: directed tests for qar_icache.
// Memory returns {16'hC0DE, addr[15:0]}; ready = valid after wait_n cycles.
module tb_qar_icache;
`ifdef QAR_ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  qar_icache_if #(.ADDR_WIDTH(32)) bus ();

  qar_icache #(.ENTRIES(8), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int total = 0;
  int bad   = 0;
  int wait_n = 0;
  int wcnt = 0;
  int nreq = 0;
  logic [31:0] req_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_ready = bus.imem_valid && (wcnt >= wait_n);
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  always @(posedge clk) begin
    if (bus.imem_valid && !bus.imem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.imem_valid && bus.imem_ready) begin
      nreq <= nreq + 1;
      req_q.push_back(bus.imem_addr);
    end
  end

  // lat = cycles from fetch_valid to fetch_ready, -1 if none in 40
  task automatic do_fetch(input logic [31:0] a, input int fl_at,
                          input int drop_at, output int lat,
                          output logic [31:0] d);
    @(negedge clk);
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = a;
    flush = (fl_at == 0);
    lat = -1;
    d = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.fetch_ready) begin
        lat = c;
        d = bus.fetch_rdata;
        break;
      end
      @(negedge clk);
      flush = (c == fl_at);
      if (c == drop_at) bus.fetch_valid = 1'b0;
    end
    @(negedge clk);
    bus.fetch_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.imem_valid !== 1'b0 || bus.fetch_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs got iv=%b fr=%b exp 0 0",
               bus.imem_valid, bus.fetch_ready);
    end
    total++;
    if (bus.fetch_rdata !== 32'h0 || bus.imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got rd=%h ia=%h exp 0 0",
               bus.fetch_rdata, bus.imem_addr);
    end
    total++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      bad++;
      $display("FAIL reset_cnt got h=%0d m=%0d exp 0 0",
               hit_count, miss_count);
    end
  endtask

  task automatic test_cold_loop();
    int lat;
    logic [31:0] d;
    int n0;
    int exp_lat;
    n0 = nreq;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        do_fetch(32'(i * 4), -1, -1, lat, d);
        exp_lat = (p == 0) ? 3 : 2;
        total++;
        if (lat !== exp_lat) begin
          bad++;
          $display("FAIL t1_lat a=%h got=%0d exp=%0d", i * 4, lat, exp_lat);
        end
        total++;
        if (d !== mem_word(32'(i * 4))) begin
          bad++;
          $display("FAIL t1_data a=%h got=%h exp=%h",
                   i * 4, d, mem_word(32'(i * 4)));
        end
      end
    end
    total++;
    if (nreq - n0 !== 8) begin
      bad++;
      $display("FAIL t1_reqs got=%0d exp=8", nreq - n0);
    end
    total++;
    if (hit_count !== (STATS ? 32'd16 : 32'd0)) begin
      bad++;
      $display("FAIL t1_hits got=%0d exp=%0d", hit_count, STATS ? 16 : 0);
    end
    total++;
    if (miss_count !== (STATS ? 32'd8 : 32'd0)) begin
      bad++;
      $display("FAIL t1_miss got=%0d exp=%0d", miss_count, STATS ? 8 : 0);
    end
  endtask

  task automatic test_alias();
    int lat;
    logic [31:0] d;
    logic [31:0] seq [3];
    seq[0] = 32'h00;
    seq[1] = 32'h20;
    seq[2] = 32'h00;
    req_q.delete();
    for (int i = 0; i < 3; i++) begin
      do_fetch(seq[i], -1, -1, lat, d);
      total++;
      if (d !== mem_word(seq[i]) || lat !== (i == 0 ? 2 : 3)) begin
        bad++;
        $display("FAIL t2_fetch a=%h got d=%h lat=%0d exp d=%h lat=%0d",
                 seq[i], d, lat, mem_word(seq[i]), i == 0 ? 2 : 3);
      end
    end
    total++;
    if (req_q.size() !== 2) begin
      bad++;
      $display("FAIL t2_reqs got=%0d exp=2", req_q.size());
    end else begin
      total++;
      if (req_q[0] !== 32'h20 || req_q[1] !== 32'h00) begin
        bad++;
        $display("FAIL t2_addrs got=%h,%h exp=20,00", req_q[0], req_q[1]);
      end
    end
  endtask

  task automatic test_wait_states();
    int lat;
    int vcyc;
    int badaddr;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_n = 4;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h10;
    lat = -1;
    vcyc = 0;
    badaddr = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (bus.imem_valid) begin
        vcyc++;
        if (bus.imem_addr !== 32'h10) badaddr++;
      end
      if (bus.fetch_ready) begin
        lat = c;
        break;
      end
    end
    @(negedge clk);
    bus.fetch_valid = 1'b0;
    wait_n = 0;
    total++;
    if (lat !== 7) begin
      bad++;
      $display("FAIL t3_lat got=%0d exp=7", lat);
    end
    total++;
    if (vcyc !== 5 || badaddr !== 0) begin
      bad++;
      $display("FAIL t3_addr got vcyc=%0d badaddr=%0d exp 5 0",
               vcyc, badaddr);
    end
  endtask

  task automatic test_flush();
    int lat;
    logic [31:0] d;
    int n0;
    for (int i = 0; i < 4; i++) do_fetch(32'(i * 4), -1, -1, lat, d);
    do_fetch(32'h00, 0, -1, lat, d);
    total++;
    if (lat !== 2 || d !== mem_word(32'h00)) begin
      bad++;
      $display("FAIL t4_preflush got lat=%0d d=%h exp 2 %h",
               lat, d, mem_word(32'h00));
    end
    n0 = nreq;
    for (int i = 0; i < 4; i++) begin
      do_fetch(32'(i * 4), -1, -1, lat, d);
      total++;
      if (lat !== 3) begin
        bad++;
        $display("FAIL t4_refetch a=%h got=%0d exp=3", i * 4, lat);
      end
    end
    total++;
    if (nreq - n0 !== 4) begin
      bad++;
      $display("FAIL t4_reqs got=%0d exp=4", nreq - n0);
    end
    do_fetch(32'h14, 1, -1, lat, d);
    total++;
    if (lat !== 3 || d !== mem_word(32'h14)) begin
      bad++;
      $display("FAIL t4_fill_flush got lat=%0d d=%h exp 3 %h",
               lat, d, mem_word(32'h14));
    end
    do_fetch(32'h14, -1, -1, lat, d);
    total++;
    if (lat !== 3) begin
      bad++;
      $display("FAIL t4_after_flush got=%0d exp=3", lat);
    end
    do_fetch(32'h14, -1, -1, lat, d);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL t4_rehit got=%0d exp=2", lat);
    end
  endtask

  task automatic test_reset_mid_refill();
    int lat;
    logic [31:0] d;
    int n0;
    wait_n = 10;
    @(negedge clk);
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h1C;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    total++;
    if (bus.imem_valid !== 1'b1) begin
      bad++;
      $display("FAIL t5_inrefill got iv=%b exp 1", bus.imem_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.imem_valid !== 1'b0 || bus.fetch_ready !== 1'b0) begin
      bad++;
      $display("FAIL t5_async got iv=%b fr=%b exp 0 0",
               bus.imem_valid, bus.fetch_ready);
    end
    bus.fetch_valid = 1'b0;
    wait_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = nreq;
    do_fetch(32'h00, -1, -1, lat, d);
    total++;
    if (lat !== 3 || nreq - n0 !== 1 || d !== mem_word(32'h00)) begin
      bad++;
      $display("FAIL t5_post got lat=%0d req=%0d d=%h exp 3 1 %h",
               lat, nreq - n0, d, mem_word(32'h00));
    end
  endtask

  task automatic test_abandon();
    int lat;
    logic [31:0] d;
    int n0;
    n0 = nreq;
    do_fetch(32'h08, -1, 1, lat, d);
    total++;
    if (lat !== -1) begin
      bad++;
      $display("FAIL t6_no_ready got lat=%0d exp -1", lat);
    end
    total++;
    if (nreq - n0 !== 1) begin
      bad++;
      $display("FAIL t6_reqs got=%0d exp=1", nreq - n0);
    end
    do_fetch(32'h08, -1, -1, lat, d);
    total++;
    if (lat !== 2 || d !== mem_word(32'h08)) begin
      bad++;
      $display("FAIL t6_hit got lat=%0d d=%h exp 2 %h",
               lat, d, mem_word(32'h08));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_addr  = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_cold_loop();
    test_alias();
    test_wait_states();
    test_flush();
    test_reset_mid_refill();
    test_abandon();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
